// File: rtl/apb_req_arbiter_if.sv
// APB bus bundle between the requester arbiter (master side) and a single completer (slave side).
interface apb_req_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin APB master sharing one completer among NUM_REQ local requesters,
// with registered SETUP/ACCESS sequencing and an optional pready timeout.
module apb_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    done,
    output logic                  err,
    output logic [DW-1:0]         rdata,
    output logic                  busy,
    apb_req_arbiter_if.master     apb
);
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [RW-1:0]         rr_reg, rr_next;
    logic [CW-1:0]         tmo_reg, tmo_next;
    logic                  psel_reg, psel_next;
    logic                  penable_reg, penable_next;
    logic                  pwrite_reg, pwrite_next;
    logic [AW-1:0]         paddr_reg, paddr_next;
    logic [DW-1:0]         pwdata_reg, pwdata_next;
    logic [NUM_REQ-1:0]    done_reg, done_next;
    logic                  err_reg, err_next;
    logic [DW-1:0]         rdata_reg, rdata_next;
    logic                  busy_reg, busy_next;

    logic [AW-1:0]         addr_arr  [NUM_REQ];
    logic [DW-1:0]         wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    eligible;
    logic                  win_found;
    logic [RW-1:0]         win_idx;
    logic [RW-1:0]         cand;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*AW +: AW];
            assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
        end
    endgenerate

    // A requester being told "done" this cycle may still show its old req; keep it out.
    assign eligible = req & ~done_reg;

    // Scan starting just after the last winner, wrapping, so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = rr_reg;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == RW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        rr_next      = rr_reg;
        tmo_next     = tmo_reg;
        psel_next    = psel_reg;
        penable_next = penable_reg;
        pwrite_next  = pwrite_reg;
        paddr_next   = paddr_reg;
        pwdata_next  = pwdata_reg;
        done_next    = '0;
        err_next     = 1'b0;
        rdata_next   = rdata_reg;

        case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    state_next   = ST_SETUP;
                    rr_next      = win_idx;
                    tmo_next     = '0;
                    psel_next    = 1'b1;
                    penable_next = 1'b0;
                    pwrite_next  = req_write[win_idx];
                    paddr_next   = addr_arr[win_idx];
                    pwdata_next  = wdata_arr[win_idx];
                end
            end
            ST_SETUP: begin
                state_next   = ST_ACCESS;
                penable_next = 1'b1;
            end
            ST_ACCESS: begin
                if (apb.pready) begin
                    state_next        = ST_IDLE;
                    psel_next         = 1'b0;
                    penable_next      = 1'b0;
                    done_next[rr_reg] = 1'b1;
                    if (!pwrite_reg) begin
                        rdata_next = apb.prdata;
                    end
                end else if ((TIMEOUT > 0) && (tmo_reg == CW'(TIMEOUT - 1))) begin
                    state_next        = ST_IDLE;
                    psel_next         = 1'b0;
                    penable_next      = 1'b0;
                    done_next[rr_reg] = 1'b1;
                    err_next          = 1'b1;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                psel_next    = 1'b0;
                penable_next = 1'b0;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_reg   <= ST_IDLE;
            rr_reg      <= RW'(NUM_REQ - 1);
            tmo_reg     <= '0;
            psel_reg    <= 1'b0;
            penable_reg <= 1'b0;
            pwrite_reg  <= 1'b0;
            paddr_reg   <= '0;
            pwdata_reg  <= '0;
            done_reg    <= '0;
            err_reg     <= 1'b0;
            rdata_reg   <= '0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rr_reg      <= rr_next;
            tmo_reg     <= tmo_next;
            psel_reg    <= psel_next;
            penable_reg <= penable_next;
            pwrite_reg  <= pwrite_next;
            paddr_reg   <= paddr_next;
            pwdata_reg  <= pwdata_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            rdata_reg   <= rdata_next;
            busy_reg    <= busy_next;
        end
    end

    assign apb.psel    = psel_reg;
    assign apb.penable = penable_reg;
    assign apb.pwrite  = pwrite_reg;
    assign apb.paddr   = paddr_reg;
    assign apb.pwdata  = pwdata_reg;
    assign done        = done_reg;
    assign err         = err_reg;
    assign rdata       = rdata_reg;
    assign busy        = busy_reg;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter against a 16x16 register-file completer with 3 wait states.
module tb_apb_req_arbiter;
    logic        pclk = 1'b0;
    logic        preset;
    logic [1:0]  req;
    logic [1:0]  req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  done;
    logic        err;
    logic [15:0] rdata;
    logic        busy;
    logic        stuck;
    logic        mem_clr;

    int total = 0;
    int bad   = 0;

    apb_req_arbiter_if #(.AW(4), .DW(16)) apb ();

    apb_req_arbiter #(.NUM_REQ(2), .AW(4), .DW(16), .TIMEOUT(16)) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .apb       (apb)
    );

    always #5 pclk = ~pclk;

    // Completer: pready in the 4th ACCESS cycle unless stuck
    logic [15:0] mem [16];
    logic [7:0]  wcnt;

    always @(posedge pclk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0;
            wcnt <= 8'd0;
        end else if (apb.psel && apb.penable) begin
            if (apb.pready) begin
                wcnt <= 8'd0;
                if (apb.pwrite) mem[apb.paddr] <= apb.pwdata;
            end else begin
                wcnt <= wcnt + 8'd1;
            end
        end else begin
            wcnt <= 8'd0;
        end
    end

    assign apb.pready = !stuck && apb.psel && apb.penable && (wcnt == 8'd3);
    assign apb.prdata = mem[apb.paddr];

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic wr, input logic [3:0] a, input logic [15:0] d);
        req_write[idx]         = wr;
        req_addr[idx*4 +: 4]   = a;
        req_wdata[idx*16 +: 16] = d;
        req[idx]               = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int limit, output int n);
        bit got;
        n   = 0;
        got = 1'b0;
        while (!got && n < limit) begin
            step();
            n++;
            if (done != 2'b00) got = 1'b1;
        end
        chk({tag, "_seen"}, 32'(got), 32'd1);
    endtask

    task automatic xfer(input string tag, input int idx, input logic wr, input logic [3:0] a,
                        input logic [15:0] d, input logic [15:0] exp_rdata);
        int n;
        set_req(idx, wr, a, d);
        wait_done(tag, 40, n);
        $display("xfer %s req=%0d wr=%0d addr=%0d cycles=%0d done=%b err=%0d rdata=%h",
                 tag, idx, wr, a, n, done, err, rdata);
        chk({tag, "_lat"}, 32'(n), 32'd6);
        chk({tag, "_done"}, 32'(done), 32'(2'b01 << idx));
        chk({tag, "_err"}, 32'(err), 32'd0);
        if (!wr) chk({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata));
        req[idx] = 1'b0;
        step();
        chk({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int cnt0;
        int cnt1;
        logic [1:0] exp_done;

        preset = 1'b1; mem_clr = 1'b1; stuck = 1'b0;
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        step(); step();
        mem_clr = 1'b0; preset = 1'b0;
        step();
        chk("rst_psel", 32'(apb.psel), 32'd0);
        chk("rst_penable", 32'(apb.penable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_paddr", 32'(apb.paddr), 32'd0);

        // 1: write then read back, edge-accurate phase check
        set_req(0, 1'b1, 4'd3, 16'hA5A5);
        step();
        chk("t1_setup_psel", 32'(apb.psel), 32'd1);
        chk("t1_setup_penable", 32'(apb.penable), 32'd0);
        chk("t1_pwrite", 32'(apb.pwrite), 32'd1);
        chk("t1_paddr", 32'(apb.paddr), 32'd3);
        chk("t1_pwdata", 32'(apb.pwdata), 32'hA5A5);
        chk("t1_busy", 32'(busy), 32'd1);
        step();
        chk("t1_access_penable", 32'(apb.penable), 32'd1);
        step(); step(); step();
        chk("t1_c5_done", 32'(done), 32'd0);
        chk("t1_c5_penable", 32'(apb.penable), 32'd1);
        step();
        $display("xfer t1_wr req=0 wr=1 addr=3 done=%b err=%0d", done, err);
        chk("t1_c6_done", 32'(done), 32'b01);
        chk("t1_c6_err", 32'(err), 32'd0);
        chk("t1_c6_psel", 32'(apb.psel), 32'd0);
        chk("t1_c6_penable", 32'(apb.penable), 32'd0);
        chk("t1_c6_busy", 32'(busy), 32'd0);
        req[0] = 1'b0;
        step();
        chk("t1_c7_done", 32'(done), 32'd0);
        xfer("t1_rd", 0, 1'b0, 4'd3, 16'h0, 16'hA5A5);

        // 2: both requesters held, alternating grants with one IDLE cycle between transfers
        preset = 1'b1; step(); preset = 1'b0; step();
        cnt0 = 0; cnt1 = 0;
        set_req(0, 1'b0, 4'd3, 16'h0);
        set_req(1, 1'b0, 4'd3, 16'h0);
        for (int p = 0; p < 6; p++) begin
            wait_done("t2", 40, n);
            exp_done = (p % 2 == 0) ? 2'b01 : 2'b10;
            $display("xfer t2 pulse=%0d done=%b rdata=%h", p, done, rdata);
            chk("t2_order", 32'(done), 32'(exp_done));
            chk("t2_rdata", 32'(rdata), 32'hA5A5);
            if (p == 0) chk("t2_first_lat", 32'(n), 32'd6);
            if (done[0]) begin cnt0++; if (cnt0 == 3) req[0] = 1'b0; end
            if (done[1]) begin cnt1++; if (cnt1 == 3) req[1] = 1'b0; end
            step();
            if (p < 5) chk("t2_gap_psel", 32'(apb.psel), 32'd1);
            else       chk("t2_end_busy", 32'(busy), 32'd0);
        end

        // 3: completer never ready -> timeout after 16 ACCESS cycles
        stuck = 1'b1;
        set_req(0, 1'b0, 4'd5, 16'h0);
        wait_done("t3", 40, n);
        $display("xfer t3 req=0 rd addr=5 cycles=%0d done=%b err=%0d rdata=%h", n, done, err, rdata);
        chk("t3_lat", 32'(n), 32'd18);
        chk("t3_done", 32'(done), 32'b01);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_psel", 32'(apb.psel), 32'd0);
        chk("t3_penable", 32'(apb.penable), 32'd0);
        chk("t3_rdata", 32'(rdata), 32'hA5A5);
        req[0] = 1'b0; stuck = 1'b0;
        step();
        chk("t3_err_clear", 32'(err), 32'd0);

        // 4: reset during the 2nd ACCESS cycle aborts the write
        set_req(0, 1'b1, 4'd9, 16'hDEAD);
        step(); step(); step();
        chk("t4_access2", 32'(apb.penable), 32'd1);
        preset = 1'b1; req = '0;
        step();
        $display("xfer t4_abort req=0 wr=1 addr=9 psel=%0d busy=%0d done=%b", apb.psel, busy, done);
        chk("t4_psel", 32'(apb.psel), 32'd0);
        chk("t4_penable", 32'(apb.penable), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        preset = 1'b0;
        step();
        chk("t4_done_after", 32'(done), 32'd0);
        set_req(0, 1'b0, 4'd9, 16'h0);
        set_req(1, 1'b0, 4'd3, 16'h0);
        wait_done("t4_a", 40, n);
        $display("xfer t4_a done=%b rdata=%h", done, rdata);
        chk("t4_first_grant", 32'(done), 32'b01);
        chk("t4_no_write", 32'(rdata), 32'h0);
        req[0] = 1'b0;
        wait_done("t4_b", 40, n);
        $display("xfer t4_b done=%b rdata=%h", done, rdata);
        chk("t4_second_grant", 32'(done), 32'b10);
        chk("t4_second_lat", 32'(n), 32'd6);
        chk("t4_second_rdata", 32'(rdata), 32'hA5A5);
        req[1] = 1'b0;
        step();

        // 5: req[1] dropped during SETUP of a read
        xfer("t5_wr", 1, 1'b1, 4'd7, 16'h7E57, 16'h0);
        set_req(1, 1'b0, 4'd7, 16'h0);
        step();
        chk("t5_setup_paddr", 32'(apb.paddr), 32'd7);
        chk("t5_setup_penable", 32'(apb.penable), 32'd0);
        req[1] = 1'b0;
        wait_done("t5", 40, n);
        $display("xfer t5_rd req=1 addr=7 done=%b rdata=%h", done, rdata);
        chk("t5_lat", 32'(n), 32'd5);
        chk("t5_done", 32'(done), 32'b10);
        chk("t5_rdata", 32'(rdata), 32'h7E57);
        step();

        // 6: address-space extremes
        xfer("t6_wr15", 0, 1'b1, 4'd15, 16'h1111, 16'h0);
        xfer("t6_wr0", 1, 1'b1, 4'd0, 16'h2222, 16'h0);
        xfer("t6_rd15", 0, 1'b0, 4'd15, 16'h0, 16'h1111);
        xfer("t6_rd0", 1, 1'b0, 4'd0, 16'h0, 16'h2222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
